// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller for a registered-read dual-port RAM: port A writes, port B reads,
// and a 2-entry output buffer gives full-rate pops. Define DPFIFO_ALMOST_FULL_EN to add almost_full.
module dpram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Both sides transfer on a cycle where valid & ready are high at the rising edge; valid never
  // depends on ready, and the offered word (wr_data / rd_data) is held stable until it transfers.
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef DPFIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_occ;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_inflight;
  logic [1:0]            r_buf_cnt;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_fetch;
  logic [2:0]            w_pend;
  logic [1:0]            w_buf_cnt_next;
  logic [DATA_WIDTH-1:0] w_head_next;
  logic [DATA_WIDTH-1:0] w_tail_next;
  logic [ADDR_WIDTH:0]   w_ram_occ_next;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Full is judged from registered occupancy only: a same-cycle fetch frees its slot next cycle.
  assign wr_ready   = (r_ram_occ != DEPTH_L);
  assign w_push     = wr_valid & wr_ready;
  assign w_pop      = r_rd_valid & rd_ready;

  assign ram_we_a   = w_push;
  assign ram_addr_a = r_wr_ptr;
  assign ram_din_a  = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = r_rd_ptr;

  // Words already committed to the buffer (held + in flight) may never exceed its two slots.
  assign w_pend  = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
  assign w_fetch = (r_ram_occ != '0) &&
                   ((w_pend < 3'd2) || ((w_pend == 3'd2) && w_pop));

  assign w_ram_occ_next = r_ram_occ + {{ADDR_WIDTH{1'b0}}, w_push}
                                    - {{ADDR_WIDTH{1'b0}}, w_fetch};
  assign w_count_next   = r_count + {{ADDR_WIDTH{1'b0}}, w_push}
                                  - {{ADDR_WIDTH{1'b0}}, w_pop};

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_head;
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_occ  <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_fetch) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_ram_occ  <= w_ram_occ_next;
      r_inflight <= w_fetch;
      r_count    <= w_count_next;
    end
  end

  // Head keeps its value when the last word pops, so rd_data holds while empty.
  always_comb begin
    w_buf_cnt_next = r_buf_cnt;
    w_head_next    = r_head;
    w_tail_next    = r_tail;
    if (w_pop && r_inflight) begin
      if (r_buf_cnt == 2'd2) begin
        w_head_next = r_tail;
        w_tail_next = ram_dout_b;
      end else begin
        w_head_next = ram_dout_b;
      end
    end else if (w_pop) begin
      w_buf_cnt_next = r_buf_cnt - 2'd1;
      if (r_buf_cnt == 2'd2) begin
        w_head_next = r_tail;
      end
    end else if (r_inflight) begin
      w_buf_cnt_next = r_buf_cnt + 2'd1;
      if (r_buf_cnt == 2'd0) begin
        w_head_next = ram_dout_b;
      end else begin
        w_tail_next = ram_dout_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_cnt  <= 2'd0;
      r_rd_valid <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_buf_cnt  <= w_buf_cnt_next;
      r_rd_valid <= (w_buf_cnt_next != 2'd0);
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
    end
  end

`ifdef DPFIFO_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic r_almost_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= AF_L);
    end
  end

  assign almost_full = r_almost_full;
`endif

  a_params: assert property (@(posedge clk)
    (ADDR_WIDTH >= 2) && (AF_LEVEL >= 0) && (AF_LEVEL <= (2 ** ADDR_WIDTH) + 2));

  a_buf_bound: assert property (@(posedge clk) disable iff (!rst_n)
    w_pend <= 3'd2);

  a_count_sum: assert property (@(posedge clk) disable iff (!rst_n)
    r_count == r_ram_occ + {{ADDR_WIDTH{1'b0}}, r_inflight}
                         + {{(ADDR_WIDTH-1){1'b0}}, r_buf_cnt});

  // Reads target occupied slots and writes free ones, so the two ports never share an address.
  a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
    (w_push && w_fetch) |-> (ram_addr_a != ram_addr_b));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: vector table for the single-word path, hand sequences for fill,
// stream, backpressure and mid-operation reset, and random traffic against a queue model.
module tb_dpram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          rd_ready = 1'b0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;

  dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // Clock/reset block and the attached RAM (registered read on port B).
  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= ram_mem[ram_addr_b];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Scoreboard state: the FIFO is modelled as an ordered queue of accepted words.
  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            model_wptr = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] held = '0;
  int            idle_run = 0;
  int            n_pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset_wr_ready", wr_ready, 1);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_count", count, 0);
      chk("reset_we_b", ram_we_b, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_wptr = 0; stall_prev = 1'b0; idle_run = 0;
  endtask

  // Driver: one clock cycle of traffic, checked against the queue model.
  task automatic tick(input logic wv, input logic [DW-1:0] wd, input logic rr);
    logic push, pop;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    if (stall_prev) begin
      chk("stall_rd_valid", rd_valid, 1);
      chk("stall_rd_data", rd_data, held);
    end
    push = wv && wr_ready;
    pop  = rd_valid && rr;
    chk("ram_we_a", ram_we_a, push);
    chk("ram_we_b", ram_we_b, 0);
    if (exp_q.size() < DEPTH) chk("wr_ready_room", wr_ready, 1);
    if (exp_q.size() == DEPTH + 2) chk("wr_ready_full", wr_ready, 0);
    if (push) begin
      chk("ram_addr_a", ram_addr_a, model_wptr % DEPTH);
      chk("ram_din_a", ram_din_a, wd);
    end
    if (pop) begin
      if (exp_q.size() == 0) chk("pop_while_empty", rd_valid, 0);
      else begin
        chk("rd_data_order", rd_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      n_pops++;
    end
    if (push) begin
      exp_q.push_back(wd);
      model_wptr++;
    end
    stall_prev = rd_valid && !rr;
    held = rd_data;
    @(posedge clk); #1;
    chk("count", count, exp_q.size());
    if (exp_q.size() > 0 && !rd_valid) idle_run++;
    else idle_run = 0;
    if (exp_q.size() > 0) chk("rd_valid_latency", (idle_run <= 2), 1);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || rd_valid) && guard < 64) begin
      tick(1'b0, '0, 1'b1);
      guard++;
    end
    chk({tag, "_drain_model_empty"}, exp_q.size(), 0);
    chk({tag, "_drain_rd_valid"}, rd_valid, 0);
    chk({tag, "_drain_count"}, count, 0);
  endtask

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_rdy;
    logic          exp_vld;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t vecs [10];
  logic bp_pat [4];

  initial begin
    // Single-word path and a short two-word exchange, cycle by cycle from reset.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 8'h00, 5'd1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 5'd1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hA5, 5'd1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5, 5'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5, 5'd0};
    vecs[5] = '{1'b1, 8'h5A, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 8'hA5, 5'd1};
    vecs[6] = '{1'b1, 8'hC3, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 8'hA5, 5'd2};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'h5A, 5'd2};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 8'hC3, 5'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'hC3, 5'd0};
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_valid = vecs[i].wv; wr_data = vecs[i].wd; rd_ready = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d_we_a", i), ram_we_a, vecs[i].exp_we);
      if (vecs[i].exp_we) chk($sformatf("vec%0d_addr_a", i), ram_addr_a, vecs[i].exp_addr);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].exp_rdy);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_vld);
      chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
    end

    // Fill to capacity (RAM plus output buffer), try one extra push, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) tick(1'b1, DW'(i), 1'b0);
    chk("fill_wr_ready_low", wr_ready, 0);
    chk("fill_count", count, DEPTH + 2);
    tick(1'b1, 8'hFF, 1'b0);
    chk("fill_extra_dropped", count, DEPTH + 2);
    drain("fill");

    // Continuous push and pop: first word out after two cycles, then one per cycle.
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 40; i++) tick(1'b1, DW'(i), 1'b1);
    chk("stream_pops", n_pops, 37);
    chk("stream_count", count, 3);
    drain("stream");

    // Backpressure with a repeating ready pattern.
    do_reset();
    for (int i = 0; i < 40; i++) tick(1'b1, DW'(8'h80 + i), bp_pat[i % 4]);
    drain("backpressure");

    // Random traffic in phases of differing push/pop pressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      case (i / 100)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 25; pr = 85; end
        2:       begin pw = 95; pr = 95; end
        default: begin pw = 50; pr = 50; end
      endcase
      tick(($urandom_range(0, 99) < pw), DW'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < pr));
    end
    drain("random");

    // Asynchronous reset with seven words held, then reuse from empty.
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, DW'(8'h40 + i), 1'b0);
    chk("midrst_count_before", count, 7);
    chk("midrst_rd_valid_before", rd_valid, 1);
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    chk("midrst_count", count, 0);
    chk("midrst_we_a", ram_we_a, 0);
    chk("midrst_we_b", ram_we_b, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_wptr = 0; stall_prev = 1'b0; idle_run = 0;
    tick(1'b1, 8'h3C, 1'b0);
    for (int g = 0; g < 5 && !rd_valid; g++) tick(1'b0, '0, 1'b0);
    chk("midrst_first_valid", rd_valid, 1);
    chk("midrst_first_data", rd_data, 8'h3C);
    drain("midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of Dual_port_ram and drives both of its ports. Port A is used only for writes and port B only for reads. A valid/ready push interface writes into the RAM. RAM read data is drained through a 2-entry output buffer, which gives a valid/ready pop interface at full throughput. The controller turns the bare dual-port RAM into a streaming buffer between producer and consumer stages.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; legal range ADDR_WIDTH >= 2.
- AF_LEVEL, 12, almost-full threshold on count; used only when DPFIFO_ALMOST_FULL_EN is defined.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  DATA_WIDTH  push data.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_ready  in  1  consumer takes the word.
- rd_data  out  DATA_WIDTH  head-of-FIFO data.
- count  out  ADDR_WIDTH+1  total words held (RAM + in-flight + output buffer).
- ram_we_a  out  1  connects to RAM we_a.
- ram_addr_a  out  ADDR_WIDTH  connects to RAM addr_a.
- ram_din_a  out  DATA_WIDTH  connects to RAM din_a.
- ram_we_b  out  1  connects to RAM we_b; constant 0.
- ram_addr_b  out  ADDR_WIDTH  connects to RAM addr_b.
- ram_dout_b  in  DATA_WIDTH  from RAM dout_b; registered, valid one cycle after ram_addr_b.

Behaviour:
- Reset values (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, ram_occ=0, inflight=0, buffer empty; wr_ready=1, rd_valid=0, rd_data=0, count=0, ram_we_a=0, ram_we_b=0.
- Reset mid-operation discards all contents; RAM contents are don't-care afterwards.
- Write path (combinational to the RAM):
  - push = wr_valid & wr_ready.
  - ram_we_a = push; ram_addr_a = wr_ptr; ram_din_a = wr_data.
  - wr_ptr increments on push and wraps modulo DEPTH.
- wr_ready = (ram_occ != DEPTH), computed from registered state only. A fetch in the same cycle does not free a slot for a write until the next cycle.
- Fetch path:
  - fetch = (ram_occ != 0) & (buf_cnt + inflight - pop < 2), where pop = rd_valid & rd_ready.
  - ram_addr_b = rd_ptr; rd_ptr increments on fetch and wraps.
  - inflight is registered to fetch.
  - The edge after inflight is high, ram_dout_b is written into the output buffer.
- ram_occ update: next = ram_occ + push - fetch. A word written at edge E is fetchable only in the cycle after E, never the same cycle.
- Output buffer: 2-entry in-order queue (head, tail).
  - rd_data = head; rd_valid = (buf_cnt != 0); both are register outputs.
  - A pop and a load in the same cycle are both honoured.
  - rd_data holds stable while rd_valid & !rd_ready.
- count: next = count + push - pop. Maximum value is DEPTH+2.
- Latency:
  - A write accepted at edge E0 into an empty FIFO gives rd_valid high after edge E2.
  - In steady state, one push and one pop per cycle are sustained with no bubbles.
- No port-A/port-B address collision is possible: reads target only occupied slots and writes target only free slots.
- Full: when ram_occ = DEPTH, wr_ready = 0 and wr_data is ignored. A push attempted while full is dropped with no state change.
- Empty: rd_valid = 0 and rd_data holds its last value. rd_ready is ignored while empty.

Optional Feature:
- Macro: DPFIFO_ALMOST_FULL_EN.
- Defined: adds output almost_full (1 bit) = registered (count_next >= AF_LEVEL); reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release -> wr_ready=1, rd_valid=0, count=0, ram_we_b=0 throughout.
2. Single word: push 0xA5 at edge E0 with rd_ready=0 -> ram_we_a pulses with addr 0; rd_valid=1 and rd_data=0xA5 after E2; count=1. Set rd_ready=1 for one cycle -> rd_valid=0, count=0.
3. Fill: push 0x00..0x11 (18 words) with rd_ready=0 -> wr_ready drops after the 18th accepted push; count=18; a 19th push of 0xFF is not accepted. Drain -> rd_data sequence 0x00..0x11 in order, then rd_valid=0.
4. Wrap and stream: wr_valid=1 and rd_ready=1 continuously for 40 cycles with data 0..39 -> after initial latency, one word out per cycle in order; pointers wrap past 15 with no loss or duplicate.
5. Backpressure: stream with rd_ready toggling 1,0,0,1 -> rd_data stable while stalled; output sequence matches input sequence exactly.
6. Mid-operation reset: assert rst_n=0 with count=7 -> all outputs return to reset values asynchronously, before the next edge. After release, push 0x3C -> first word read is 0x3C.
